fpu_lane_sequencer: RTL
=======================

# fpu_lane_sequencer

Upstream dispatch stage for the 32-bit vector-ALU floating-point unit. Accepts one vector FP instruction (LANES operand pairs, an execution mask, operation and rounding mode), issues the active lanes one per cycle into the single scalar FPU, and collects the returned results. It then presents the assembled result vector with the OR-reduced exception flags to the writeback stage over a valid/ready handshake.

## Interface
- BIT_WIDTH, 32, width of one lane operand/result
- LANES, 4, lanes per vector instruction (≥1)
- FPU_LATENCY, 1, cycles from an FPU issue cycle to the cycle its result/flags are valid (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  sequencer can accept (high only in IDLE)
- in_mode  in  3  rounding mode, passed through unchanged
- in_operation  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- in_exec_mask  in  LANES  bit i set = lane i active
- in_srcA, in_srcB  in  LANES*BIT_WIDTH  lane i at [i*BIT_WIDTH +: BIT_WIDTH]
- fpu_valid  out  1  issue strobe to FPU
- fpu_mode  out  3  latched in_mode
- fpu_operation  out  2  latched in_operation
- fpu_inputA, fpu_inputB  out  BIT_WIDTH  operands of the lane being issued
- fpu_result  in  BIT_WIDTH  FPU result
- fpu_exception  in  5  [4] overflow, [3] underflow, [2] div-by-zero, [1] invalid, [0] inexact
- out_valid  out  1  result vector available
- out_ready  in  1  consumer accepts
- out_result  out  LANES*BIT_WIDTH  assembled results, same lane packing as inputs
- out_exception  out  5  OR of fpu_exception over active lanes
- out_exec_mask  out  LANES  latched mask

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid: latch mode, operation, mask, srcA, srcB; clear the result vector and out_exception. Next state is ISSUE if mask≠0, otherwise DONE.
- ISSUE: each cycle, select the lowest-index active lane not yet issued, assert fpu_valid, and drive its operands. Push the lane index into an FPU_LATENCY-deep tag pipeline with a valid bit. After the last active lane is issued, go to DRAIN.
- DRAIN: wait until the tag pipeline is empty, then go to DONE.
- Capture: when the tag pipeline output is valid, write fpu_result into lane slot tag and OR fpu_exception into out_exception. Capture operates in ISSUE and DRAIN.
- DONE: out_valid=1; outputs held stable until out_ready. On the transfer cycle, go to IDLE.
- Inactive lanes: result slot is 0 and they contribute no flags. Inactive lanes are never issued.
- fpu_valid=0 outside ISSUE. fpu_inputA/B = 0 when fpu_valid=0. fpu_mode and fpu_operation hold their latched values.
- Reset, including mid-ISSUE/DRAIN: state goes to IDLE, tag pipeline valid bits are cleared, and in-flight FPU results are discarded.

## Timing
- Reset values: in_ready=1 (state IDLE after the reset cycle), fpu_valid=0, fpu_inputA/B=0, fpu_mode=0, fpu_operation=0, out_valid=0, out_result=0, out_exception=0, out_exec_mask=0.
- Accept in cycle T (in_valid & in_ready). With k active lanes (k≥1):
  - fpu_valid is high in cycles T+1..T+k.
  - The result for the issue in cycle c is sampled in cycle c+FPU_LATENCY.
  - out_valid rises in cycle T+k+FPU_LATENCY+1.
- With k=0: out_valid rises in cycle T+1.
- in_ready is low from T+1 until the cycle after the output transfer; there is no same-cycle accept/emit bypass.
- Throughput: one instruction per k+FPU_LATENCY+2 cycles with out_ready held high.
- in_* inputs are ignored outside IDLE; they are latched, so callers need not hold them.

## Test plan
- All lanes, ADD, FPU_LATENCY=1, out_ready=1: lane i computes A=1.0 (0x3F800000) + B=i+1.0.
  - fpu_valid in T+1..T+4.
  - out_valid at T+6 with results 0x40000000, 0x40400000, 0x40800000, 0x40A00000, out_exception=0.
- Mask 4'b0101, MUL, 2.0×3.0 on all lanes:
  - Exactly 2 issues, lanes 0 then 2.
  - out_result lanes 0,2 = 0x40C00000; lanes 1,3 = 0; out_valid at T+4.
- Mask 0: no fpu_valid, out_valid at T+1, out_result=0, out_exception=0.
- DIV with lane 1 B=0.0 and lane 3 overflowing: out_exception has bits [2] and [4] set, and other flags follow the FPU.
- Backpressure: out_ready low for 5 cycles after out_valid.
  - Outputs stay stable and in_ready stays 0.
  - A transfer on the 6th cycle; in_ready returns high the next cycle.
- rst asserted in the 2nd ISSUE cycle:
  - Next cycle state is IDLE with all outputs at reset values.
  - A following instruction produces only its own results; no stale capture occurs.

Source files
------------

// File: rtl/fpu_lane_sequencer.sv
// fpu_lane_sequencer
// Dispatch stage in front of a single scalar FPU. It accepts one vector FP
// instruction, issues its active lanes one per cycle (lowest index first),
// collects the returned results and flags, and hands the assembled vector to
// writeback over a valid/ready handshake.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           instruction handshake (ready only while idle)
//   in_mode, in_operation         rounding mode and opcode, latched on accept
//   in_exec_mask                  per-lane enable
//   in_srcA, in_srcB              packed lane operands, lane i at [i*BIT_WIDTH +: BIT_WIDTH]
//   fpu_valid                     issue strobe to the scalar FPU
//   fpu_mode, fpu_operation       latched mode/opcode
//   fpu_inputA, fpu_inputB        operands of the lane being issued (0 when idle)
//   fpu_result, fpu_exception     FPU return path, valid FPU_LATENCY cycles after issue
//   out_valid / out_ready         result handshake
//   out_result                    assembled results, inactive lanes read 0
//   out_exception                 OR of flags over active lanes
//   out_exec_mask                 latched lane mask
module fpu_lane_sequencer #(
    parameter int BIT_WIDTH   = 32,
    parameter int LANES       = 4,
    parameter int FPU_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_mode,
    input  logic [1:0]                 in_operation,
    input  logic [LANES-1:0]           in_exec_mask,
    input  logic [LANES*BIT_WIDTH-1:0] in_srcA,
    input  logic [LANES*BIT_WIDTH-1:0] in_srcB,
    output logic                       fpu_valid,
    output logic [2:0]                 fpu_mode,
    output logic [1:0]                 fpu_operation,
    output logic [BIT_WIDTH-1:0]       fpu_inputA,
    output logic [BIT_WIDTH-1:0]       fpu_inputB,
    input  logic [BIT_WIDTH-1:0]       fpu_result,
    input  logic [4:0]                 fpu_exception,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*BIT_WIDTH-1:0] out_result,
    output logic [4:0]                 out_exception,
    output logic [LANES-1:0]           out_exec_mask
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [IDX_W-1:0] lowest_lane(input logic [LANES-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // One-hot lane bit for a lane index.
    function automatic logic [LANES-1:0] lane_bit(input logic [IDX_W-1:0] idx);
        logic [LANES-1:0] b;
        b = '0;
        b[idx] = 1'b1;
        return b;
    endfunction

    logic [1:0]                        state_r;
    logic                              in_ready_r;
    logic                              out_valid_r;
    logic                              fpu_valid_r;
    logic [BIT_WIDTH-1:0]              fpu_a_r;
    logic [BIT_WIDTH-1:0]              fpu_b_r;
    logic [2:0]                        mode_r;
    logic [1:0]                        op_r;
    logic [LANES-1:0]                  mask_r;
    logic [LANES*BIT_WIDTH-1:0]        src_a_r;
    logic [LANES*BIT_WIDTH-1:0]        src_b_r;
    logic [LANES*BIT_WIDTH-1:0]        result_r;
    logic [4:0]                        exc_r;
    // Lanes still waiting to be issued after the one currently on the FPU port.
    logic [LANES-1:0]                  rem_r;
    logic [IDX_W-1:0]                  issue_lane_r;
    // Lane-tag pipeline that tracks in-flight FPU operations.
    logic [FPU_LATENCY-1:0]            tag_vld_r;
    logic [FPU_LATENCY-1:0][IDX_W-1:0] tag_r;

    logic [IDX_W-1:0]                  first_lane_s;
    logic [IDX_W-1:0]                  next_lane_s;
    logic                              drain_done_s;

    // Next-lane selection and end-of-drain detection.
    always_comb begin
        first_lane_s = lowest_lane(in_exec_mask);
        next_lane_s  = lowest_lane(rem_r);
        // The last result is on the FPU port once every stage but the output one is empty.
        drain_done_s = 1'b1;
        for (int i = 0; i < FPU_LATENCY - 1; i++) begin
            if (tag_vld_r[i]) drain_done_s = 1'b0;
            else              drain_done_s = drain_done_s;
        end
    end

    // Sequencer state, issue port, tag pipeline and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            fpu_valid_r  <= 1'b0;
            fpu_a_r      <= '0;
            fpu_b_r      <= '0;
            mode_r       <= 3'd0;
            op_r         <= 2'd0;
            mask_r       <= '0;
            src_a_r      <= '0;
            src_b_r      <= '0;
            result_r     <= '0;
            exc_r        <= 5'd0;
            rem_r        <= '0;
            issue_lane_r <= '0;
            tag_vld_r    <= '0;
            tag_r        <= '0;
        end else begin
            tag_vld_r[0] <= (state_r == ST_ISSUE) && fpu_valid_r;
            tag_r[0]     <= issue_lane_r;
            for (int i = FPU_LATENCY - 1; i > 0; i--) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_r[i]     <= tag_r[i-1];
            end

            if (((state_r == ST_ISSUE) || (state_r == ST_DRAIN)) && tag_vld_r[FPU_LATENCY-1]) begin
                result_r[tag_r[FPU_LATENCY-1]*BIT_WIDTH +: BIT_WIDTH] <= fpu_result;
                exc_r <= exc_r | fpu_exception;
            end

            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_r     <= in_mode;
                        op_r       <= in_operation;
                        mask_r     <= in_exec_mask;
                        src_a_r    <= in_srcA;
                        src_b_r    <= in_srcB;
                        result_r   <= '0;
                        exc_r      <= 5'd0;
                        in_ready_r <= 1'b0;
                        if (in_exec_mask != '0) begin
                            // First lane goes out on the very next cycle, straight from the inputs.
                            state_r      <= ST_ISSUE;
                            fpu_valid_r  <= 1'b1;
                            fpu_a_r      <= in_srcA[first_lane_s*BIT_WIDTH +: BIT_WIDTH];
                            fpu_b_r      <= in_srcB[first_lane_s*BIT_WIDTH +: BIT_WIDTH];
                            issue_lane_r <= first_lane_s;
                            rem_r        <= in_exec_mask & ~lane_bit(first_lane_s);
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (rem_r != '0) begin
                        fpu_a_r      <= src_a_r[next_lane_s*BIT_WIDTH +: BIT_WIDTH];
                        fpu_b_r      <= src_b_r[next_lane_s*BIT_WIDTH +: BIT_WIDTH];
                        issue_lane_r <= next_lane_s;
                        rem_r        <= rem_r & ~lane_bit(next_lane_s);
                    end else begin
                        state_r     <= ST_DRAIN;
                        fpu_valid_r <= 1'b0;
                        fpu_a_r     <= '0;
                        fpu_b_r     <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    fpu_valid_r <= 1'b0;
                    fpu_a_r     <= '0;
                    fpu_b_r     <= '0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_r;
    assign fpu_valid     = fpu_valid_r;
    assign fpu_mode      = mode_r;
    assign fpu_operation = op_r;
    assign fpu_inputA    = fpu_a_r;
    assign fpu_inputB    = fpu_b_r;
    assign out_valid     = out_valid_r;
    assign out_result    = result_r;
    assign out_exception = exc_r;
    assign out_exec_mask = mask_r;

endmodule
